// File: rtl/interrupt_dispatch_if.sv
// Byte-wide memory bus between the interrupt dispatcher (master) and the
// register/memory slave. read_out is combinational from addr_select.
interface mem_if;
   logic [15:0] addr_select;
   logic        write_enable;
   logic [7:0]  write_value;
   logic [7:0]  read_out;

   modport master (
      output addr_select,
      output write_enable,
      output write_value,
      input  read_out
   );

   modport slave (
      input  addr_select,
      input  write_enable,
      input  write_value,
      output read_out
   );
endinterface

// File: rtl/interrupt_dispatch.sv
// Polls IF/IE over the memory bus, reports pending interrupts, and on a core
// grant acknowledges the winning IF bit, pushes the return PC and returns the vector.
module interrupt_dispatch #(
   parameter int WE_HOLD = 2
) (
   input  logic        clk,
   input  logic        rst,
   mem_if.master       bus,
   input  logic        ime,
   input  logic        start,
   input  logic [15:0] pc,
   input  logic [15:0] sp,
   output logic        irq_pending,
   output logic        busy,
   output logic        done,
   output logic        cancelled,
   output logic [15:0] new_pc,
   output logic [15:0] new_sp,
   output logic        clr_ime
);

   localparam int HOLD_W = (WE_HOLD > 2) ? $clog2(WE_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WE_HOLD - 1);
   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_IF = 3'd1,
      ST_WRITE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Lowest set bit wins: VBlank has the highest priority.
   function automatic logic [2:0] lowest_bit(input logic [4:0] v);
      logic [2:0] r;
      casez (v)
         5'b????1: r = 3'd0;
         5'b???10: r = 3'd1;
         5'b??100: r = 3'd2;
         5'b?1000: r = 3'd3;
         5'b10000: r = 3'd4;
         default:  r = 3'd0;
      endcase
      return r;
   endfunction

   state_t            state_r, state_s;
   logic              phase_r, phase_s;
   logic [1:0]        step_r, step_s;
   logic [HOLD_W-1:0] hold_r, hold_s;
   logic [15:0]       pc_r, pc_s;
   logic [15:0]       sp_r, sp_s;
   logic [2:0]        idx_r, idx_s;
   logic [4:0]        if_r, if_s;
   logic [4:0]        ie_r, ie_s;
   logic [4:0]        pend_s;
   logic [15:0]       addr_r, addr_s;
   logic              we_r, we_s;
   logic [7:0]        wv_r, wv_s;
   logic              irq_r, irq_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              canc_r, canc_s;
   logic              clr_ime_r, clr_ime_s;
   logic [15:0]       new_pc_r, new_pc_s;
   logic [15:0]       new_sp_r, new_sp_s;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s   = state_r;
      phase_s   = phase_r;
      step_s    = step_r;
      hold_s    = hold_r;
      pc_s      = pc_r;
      sp_s      = sp_r;
      idx_s     = idx_r;
      if_s      = if_r;
      ie_s      = ie_r;
      pend_s    = 5'd0;
      addr_s    = addr_r;
      we_s      = 1'b0;
      wv_s      = wv_r;
      done_s    = 1'b0;
      canc_s    = canc_r;
      clr_ime_s = 1'b0;
      new_pc_s  = new_pc_r;
      new_sp_s  = new_sp_r;
      case (state_r)
         ST_IDLE: begin
            if (phase_r == 1'b0) begin
               if_s = bus.read_out[4:0];
            end else begin
               ie_s = bus.read_out[4:0];
            end
            if (start && ime && irq_r) begin
               state_s = ST_RD_IF;
               pc_s    = pc;
               sp_s    = sp;
               phase_s = 1'b0;
               addr_s  = ADDR_IF;
            end else begin
               phase_s = ~phase_r;
               addr_s  = (phase_r == 1'b0) ? ADDR_IE : ADDR_IF;
            end
         end
         ST_RD_IF: begin
            if_s   = bus.read_out[4:0];
            pend_s = if_s & ie_r;
            if (pend_s == 5'd0) begin
               state_s = ST_DONE;
               done_s  = 1'b1;
               canc_s  = 1'b1;
            end else begin
               idx_s   = lowest_bit(pend_s);
               state_s = ST_WRITE;
               step_s  = 2'd0;
               hold_s  = '0;
               we_s    = 1'b1;
               addr_s  = ADDR_IF;
               wv_s    = {3'b000, if_s & ~(5'b00001 << idx_s)};
            end
         end
         ST_WRITE: begin
            if (hold_r == HOLD_LAST) begin
               state_s = ST_GAP;
            end else begin
               hold_s = hold_r + HOLD_W'(1);
               we_s   = 1'b1;
            end
         end
         // Address and data stay put through GAP so the slave sees a clean WE drop.
         ST_GAP: begin
            hold_s = '0;
            case (step_r)
               2'd0: begin
                  state_s = ST_WRITE;
                  step_s  = 2'd1;
                  we_s    = 1'b1;
                  addr_s  = sp_r - 16'd1;
                  wv_s    = pc_r[15:8];
               end
               2'd1: begin
                  state_s = ST_WRITE;
                  step_s  = 2'd2;
                  we_s    = 1'b1;
                  addr_s  = sp_r - 16'd2;
                  wv_s    = pc_r[7:0];
               end
               default: begin
                  state_s   = ST_DONE;
                  done_s    = 1'b1;
                  canc_s    = 1'b0;
                  clr_ime_s = 1'b1;
                  new_pc_s  = 16'h0040 + {10'd0, idx_r, 3'b000};
                  new_sp_s  = sp_r - 16'd2;
               end
            endcase
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            phase_s = 1'b0;
            addr_s  = ADDR_IF;
         end
         default: begin
            state_s = ST_IDLE;
            phase_s = 1'b0;
            addr_s  = ADDR_IF;
         end
      endcase
      irq_s  = |(if_s & ie_s);
      busy_s = (state_s != ST_IDLE);
   end

   // State, captured operands and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         phase_r   <= 1'b0;
         step_r    <= 2'd0;
         hold_r    <= '0;
         pc_r      <= 16'd0;
         sp_r      <= 16'd0;
         idx_r     <= 3'd0;
         if_r      <= 5'd0;
         ie_r      <= 5'd0;
         addr_r    <= ADDR_IF;
         we_r      <= 1'b0;
         wv_r      <= 8'd0;
         irq_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         canc_r    <= 1'b0;
         clr_ime_r <= 1'b0;
         new_pc_r  <= 16'd0;
         new_sp_r  <= 16'd0;
      end else begin
         state_r   <= state_s;
         phase_r   <= phase_s;
         step_r    <= step_s;
         hold_r    <= hold_s;
         pc_r      <= pc_s;
         sp_r      <= sp_s;
         idx_r     <= idx_s;
         if_r      <= if_s;
         ie_r      <= ie_s;
         addr_r    <= addr_s;
         we_r      <= we_s;
         wv_r      <= wv_s;
         irq_r     <= irq_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         canc_r    <= canc_s;
         clr_ime_r <= clr_ime_s;
         new_pc_r  <= new_pc_s;
         new_sp_r  <= new_sp_s;
      end
   end

   assign bus.addr_select  = addr_r;
   assign bus.write_enable = we_r;
   assign bus.write_value  = wv_r;
   assign irq_pending      = irq_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign cancelled        = canc_r;
   assign clr_ime          = clr_ime_r;
   assign new_pc           = new_pc_r;
   assign new_sp           = new_sp_r;

endmodule

// File: tb/tb_interrupt_dispatch.sv
// Bench for interrupt_dispatch: a byte-memory slave that commits on the second
// WE-high cycle, with a scoreboard of expected committed writes.
module tb_interrupt_dispatch;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ime, start;
   logic [15:0] pc, sp;
   logic        irq_pending, busy, done, cancelled, clr_ime;
   logic [15:0] new_pc, new_sp;

   logic        ext_we;
   logic [15:0] ext_addr;
   logic [7:0]  ext_data;

   bit [7:0]    mem [0:65535];
   int          we_cnt;
   int          we_cycles;
   int          n_cmp = 0;
   int          n_bad = 0;
   wr_t         exp_q[$];

   mem_if bus_if ();

   interrupt_dispatch #(.WE_HOLD(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if.master),
      .ime         (ime),
      .start       (start),
      .pc          (pc),
      .sp          (sp),
      .irq_pending (irq_pending),
      .busy        (busy),
      .done        (done),
      .cancelled   (cancelled),
      .new_pc      (new_pc),
      .new_sp      (new_sp),
      .clr_ime     (clr_ime)
   );

   always #5 clk = ~clk;

   assign bus_if.read_out = mem[bus_if.addr_select];

   // Slave: commit on the second consecutive WE-high cycle and score the write.
   always @(posedge clk) begin : slave
      wr_t e;
      wr_t got;
      if (ext_we === 1'b1) mem[ext_addr] <= ext_data;
      if (bus_if.write_enable === 1'b1) begin
         we_cycles++;
         if (we_cnt == 1) begin
            mem[bus_if.addr_select] <= bus_if.write_value;
            got = {bus_if.addr_select, bus_if.write_value};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: got %h<-%h, none expected", got.a, got.d);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL bus_write: got %h<-%h, want %h<-%h", got.a, got.d, e.a, e.d);
               end
            end
         end
         if (we_cnt < 3) we_cnt <= we_cnt + 1;
      end else begin
         we_cnt <= 0;
      end
   end

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      ext_addr = a;
      ext_data = d;
      ext_we   = 1'b1;
      @(negedge clk);
      ext_we   = 1'b0;
   endtask

   // Grant one dispatch and return the cycle (after the start cycle) where done rose.
   task automatic dispatch(input logic [15:0] p, input logic [15:0] s, output int lat);
      @(negedge clk);
      pc    = p;
      sp    = s;
      ime   = 1'b1;
      start = 1'b1;
      lat   = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; ime = 1'b0; start = 1'b0; pc = 16'd0; sp = 16'd0;
      ext_we = 1'b0; ext_addr = 16'd0; ext_data = 8'd0; we_cycles = 0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus_if.addr_select, bus_if.write_enable, bus_if.write_value} !== {16'hFF0F, 1'b0, 8'h00}) begin
         n_bad++;
         $display("FAIL reset_bus: got %h/%b/%h, want ff0f/0/00",
                  bus_if.addr_select, bus_if.write_enable, bus_if.write_value);
      end
      n_cmp++;
      if ({irq_pending, busy, done, cancelled, clr_ime, new_pc, new_sp} !== {5'b00000, 16'h0000, 16'h0000}) begin
         n_bad++;
         $display("FAIL reset_outputs: got irq%b busy%b done%b canc%b clr%b pc%h sp%h, want all zero",
                  irq_pending, busy, done, cancelled, clr_ime, new_pc, new_sp);
      end
      rst = 1'b1;
   endtask

   task automatic test_basic_vblank;
      int lat;
      poke(16'hFFFF, 8'h01);
      poke(16'hFF0F, 8'h01);
      ime = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (irq_pending !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_irq_pending: got %b, want 1", irq_pending);
      end
      exp_q.push_back({16'hFF0F, 8'h00});
      exp_q.push_back({16'hFFFD, 8'h12});
      exp_q.push_back({16'hFFFC, 8'h34});
      dispatch(16'h1234, 16'hFFFE, lat);
      n_cmp++;
      if (lat !== 11) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d, want 11", lat);
      end
      n_cmp++;
      if ({new_pc, new_sp, clr_ime, cancelled, busy} !== {16'h0040, 16'hFFFC, 1'b1, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL basic_result: got pc%h sp%h clr%b canc%b busy%b, want pc0040 spfffc clr1 canc0 busy1",
                  new_pc, new_sp, clr_ime, cancelled, busy);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, clr_ime, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL basic_pulse_end: got done%b clr%b busy%b, want 000", done, clr_ime, busy);
      end
      n_cmp++;
      if (mem[16'hFF0F] !== 8'h00 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL basic_slave_if: got IF=%h pending_writes=%0d, want IF=00 pending_writes=0",
                  mem[16'hFF0F], exp_q.size());
      end
   endtask

   task automatic test_priority;
      int lat;
      poke(16'hFFFF, 8'h1F);
      poke(16'hFF0F, 8'h14);
      repeat (4) @(negedge clk);
      exp_q.push_back({16'hFF0F, 8'h10});
      exp_q.push_back({16'hBFFF, 8'h43});
      exp_q.push_back({16'hBFFE, 8'h21});
      dispatch(16'h4321, 16'hC000, lat);
      n_cmp++;
      if ({lat == 11, new_pc, new_sp} !== {1'b1, 16'h0050, 16'hBFFE}) begin
         n_bad++;
         $display("FAIL priority_timer: got lat%0d pc%h sp%h, want lat11 pc0050 spbffe", lat, new_pc, new_sp);
      end
      repeat (4) @(negedge clk);
      exp_q.push_back({16'hFF0F, 8'h00});
      exp_q.push_back({16'hBFFD, 8'h67});
      exp_q.push_back({16'hBFFC, 8'h89});
      dispatch(16'h6789, 16'hBFFE, lat);
      n_cmp++;
      if ({lat == 11, new_pc, new_sp} !== {1'b1, 16'h0060, 16'hBFFC}) begin
         n_bad++;
         $display("FAIL priority_joypad: got lat%0d pc%h sp%h, want lat11 pc0060 spbffc", lat, new_pc, new_sp);
      end
      @(negedge clk);
      n_cmp++;
      if (mem[16'hFF0F] !== 8'h00 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL priority_slave_if: got IF=%h pending_writes=%0d, want 00/0", mem[16'hFF0F], exp_q.size());
      end
   endtask

   task automatic test_gating;
      poke(16'hFFFF, 8'h01);
      poke(16'hFF0F, 8'h01);
      ime = 1'b0;
      repeat (4) @(negedge clk);
      we_cycles = 0;
      start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || irq_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL gating_ime: got busy%b irq%b, want busy0 irq1", busy, irq_pending);
         end
      end
      start = 1'b0;
      poke(16'hFFFF, 8'h00);
      poke(16'hFF0F, 8'h1F);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (irq_pending !== 1'b0) begin
         n_bad++;
         $display("FAIL gating_ie_irq: got %b, want 0", irq_pending);
      end
      ime   = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL gating_ie_start: got busy%b done%b, want 00", busy, done);
         end
      end
      start = 1'b0;
      n_cmp++;
      if (we_cycles != 0) begin
         n_bad++;
         $display("FAIL gating_writes: got %0d WE cycles, want 0", we_cycles);
      end
   endtask

   task automatic test_cancel;
      int lat;
      poke(16'hFFFF, 8'h04);
      poke(16'hFF0F, 8'h04);
      repeat (4) @(negedge clk);
      we_cycles = 0;
      @(negedge clk);
      pc = 16'h1111; sp = 16'h2222; ime = 1'b1; start = 1'b1;
      ext_addr = 16'hFF0F; ext_data = 8'h00; ext_we = 1'b1;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start  = 1'b0;
         ext_we = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      n_cmp++;
      if ({lat == 2, cancelled, clr_ime} !== 3'b110) begin
         n_bad++;
         $display("FAIL cancel_done: got lat%0d canc%b clr%b, want lat2 canc1 clr0", lat, cancelled, clr_ime);
      end
      n_cmp++;
      if ({new_pc, new_sp} !== {16'h0060, 16'hBFFC} || we_cycles != 0) begin
         n_bad++;
         $display("FAIL cancel_held: got pc%h sp%h we_cycles%0d, want pc0060 spbffc we_cycles0",
                  new_pc, new_sp, we_cycles);
      end
   endtask

   task automatic test_sp_wrap;
      int lat;
      poke(16'hFFFF, 8'h08);
      poke(16'hFF0F, 8'h08);
      repeat (4) @(negedge clk);
      exp_q.push_back({16'hFF0F, 8'h00});
      exp_q.push_back({16'hFFFF, 8'hBE});
      exp_q.push_back({16'hFFFE, 8'hEF});
      dispatch(16'hBEEF, 16'h0000, lat);
      n_cmp++;
      if ({lat == 11, new_pc, new_sp} !== {1'b1, 16'h0058, 16'hFFFE}) begin
         n_bad++;
         $display("FAIL sp_wrap: got lat%0d pc%h sp%h, want lat11 pc0058 spfffe", lat, new_pc, new_sp);
      end
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sp_wrap_writes: got %0d writes missing, want 0", exp_q.size());
      end
      poke(16'hFFFF, 8'h00);
   endtask

   task automatic test_reset_mid_push;
      logic seen_done;
      poke(16'hFFFF, 8'h01);
      poke(16'h7FFF, 8'h77);
      poke(16'hFF0F, 8'h01);
      repeat (4) @(negedge clk);
      exp_q.push_back({16'hFF0F, 8'h00});
      seen_done = 1'b0;
      @(negedge clk);
      pc = 16'hA5A5; sp = 16'h8000; ime = 1'b1; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_cmp++;
      if ({bus_if.write_enable, bus_if.addr_select, bus_if.write_value} !== {1'b1, 16'h7FFF, 8'hA5}) begin
         n_bad++;
         $display("FAIL rstmid_push_hi: got we%b %h<-%h, want we1 7fff<-a5",
                  bus_if.write_enable, bus_if.addr_select, bus_if.write_value);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus_if.write_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_we_drop: got %b, want 0", bus_if.write_enable);
      end
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
      n_cmp++;
      if ({bus_if.addr_select, bus_if.write_value, irq_pending, busy, cancelled, clr_ime, new_pc, new_sp}
          !== {16'hFF0F, 8'h00, 4'b0000, 16'h0000, 16'h0000} || seen_done) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got addr%h wv%h irq%b busy%b canc%b clr%b pc%h sp%h done_seen%b, want reset values",
                  bus_if.addr_select, bus_if.write_value, irq_pending, busy, cancelled, clr_ime,
                  new_pc, new_sp, seen_done);
      end
      n_cmp++;
      if (mem[16'h7FFF] !== 8'h77 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL rstmid_stack: got mem[7fff]=%h pending_writes=%0d, want 77/0", mem[16'h7FFF], exp_q.size());
      end
      rst = 1'b1;
      poke(16'hFF0F, 8'h01);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (irq_pending !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_poll_resume: got irq%b busy%b, want irq1 busy0", irq_pending, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic_vblank();
      test_priority();
      test_gating();
      test_cancel();
      test_sp_wrap();
      test_reset_mid_push();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/interrupt_dispatch.md
# interrupt_dispatch

Master-side counterpart of the interrupt register block. It polls IF (0xFF0F) and IE (0xFFFF) over a `mem_if` master port and reports pending interrupts to the CPU core. When the core grants service at an instruction boundary, it runs the full dispatch sequence:
- acknowledge (clear) the highest-priority IF bit;
- push the return PC onto the stack;
- hand the vector address and updated SP back to the core.

## Interface
- `WE_HOLD`, default 2: cycles `write_enable` is held per bus write. Must be ≥2, because the slave commits on the second consecutive WE-high cycle.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **synchronous, active-low reset**. `rst==0` sampled at a rising edge resets all state.
- `bus` `mem_if.master`: drives `addr_select` [15:0], `write_enable`, `write_value` [7:0]; samples `read_out` [7:0], which is combinational from the slave in the same cycle.
- `ime` in 1: CPU interrupt master enable.
- `start` in 1: core grants dispatch (instruction boundary). Sampled only in IDLE.
- `pc` in 16: return address to push. Sampled on accepted `start`.
- `sp` in 16: current stack pointer. Sampled on accepted `start`.
- `irq_pending` out 1: `(if_q & ie_q & 5'h1F) != 0`. Independent of `ime`; also used as HALT wake.
- `busy` out 1: high from the cycle after accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse at end of dispatch.
- `cancelled` out 1: valid with `done`. Means the interrupt vanished before acknowledge; no writes were issued.
- `new_pc` out 16: vector; valid with `done`, held until next `done`.
- `new_sp` out 16: `sp-2`; valid with `done`, held until next `done`.
- `clr_ime` out 1: one-cycle pulse coincident with a non-cancelled `done`.

## Operation
- Registers `if_q`/`ie_q` are 5-bit, bits [4:0].
- IDLE polling alternates each cycle:
  - phase A: `addr_select=FF0F`, sample `read_out[4:0]` into `if_q` at the edge;
  - phase B: `addr_select=FFFF`, sample into `ie_q`.
- Accept: in IDLE with `start && ime && irq_pending` → latch `pc`, `sp`; go to RD_IF. `start` otherwise ignored, including while busy.
- RD_IF (1 cycle): `addr=FF0F`; re-sample IF into `if_q`.
  - If `if_q_new & ie_q` is 0 → DONE with `cancelled=1`.
  - Else latch `idx` = lowest set bit of `if_q_new & ie_q`.
- Priority: bit0 VBlank > 1 LCD STAT > 2 Timer > 3 Serial > 4 Joypad.
- Vector: `new_pc = 16'h0040 + {idx,3'b000}` (0x40/48/50/58/60).
- CLR_IF: `addr=FF0F`, `write_value={3'b0, if_q & ~(1<<idx)}`, WE high for `WE_HOLD` cycles, then GAP.
- PUSH_HI: `addr=sp-1`, `value=pc[15:8]`, WE for `WE_HOLD` cycles, then GAP.
- PUSH_LO: `addr=sp-2`, `value=pc[7:0]`, WE for `WE_HOLD` cycles, then GAP.
- GAP: 1 cycle with WE low and address held. This resets the slave WE counter between writes.
- DONE: 1 cycle. `done=1`; `new_sp=sp-2` (unless cancelled); `clr_ime=~cancelled`. Next state IDLE, polling resumes at phase A.
- Arithmetic is 16-bit modulo:
  - `sp=0x0001` → writes 0x0000, 0xFFFF; `new_sp=0xFFFF`.
  - `sp=0x0000` → writes 0xFFFF, 0xFFFE; `new_sp=0xFFFE`.
- An IF bit raised by hardware between RD_IF and the end of CLR_IF may be overwritten. This window is accepted; the cost is bounded at `WE_HOLD+1` cycles.
- Reset values: `addr_select=FF0F`, `write_enable=0`, `write_value=0`, `if_q=ie_q=0`, `irq_pending=0`, `busy=0`, `done=0`, `cancelled=0`, `clr_ime=0`, `new_pc=0`, `new_sp=0`, state IDLE phase A.
- Reset mid-dispatch: the next edge returns to IDLE and drops WE. A write whose WE was high for fewer than 2 cycles is not committed by the slave. No `done` is issued.

## Timing
- Poll period: 2 cycles. `irq_pending` reflects a new IF bit within 2–3 cycles of it appearing in the slave.
- Dispatch length: `1 + 3*(WE_HOLD+1) + 1` cycles after the accept edge. For `WE_HOLD=2`, `done` is high in the 11th cycle after the cycle `start` was sampled.
- Cancelled dispatch: `done` in the 2nd cycle after accept.
- All outputs are registered. Bus address and data are stable for the entire WE window and its GAP.
- `start` high in the same cycle as `done` is ignored; the next accept is possible one cycle later.

## Test plan
- **Basic VBlank:**
  - stimulus: IE=0x01, IF=0x01, `ime=1`, `pc=0x1234`, `sp=0xFFFE`, `start`;
  - writes: FF0F←0x00, FFFD←0x12, FFFC←0x34;
  - `done` at +11; `new_pc=0x0040`, `new_sp=0xFFFC`, `clr_ime` pulse; slave IF=0x00 afterwards.
- **Priority:**
  - stimulus: IE=0x1F, IF=0x14;
  - required: idx=2, `new_pc=0x0050`, IF written 0x10;
  - a second dispatch then gives `new_pc=0x0060`, IF 0x00.
- **Gating:**
  - `ime=0` with pending: `start` ignored, `busy` stays 0, `irq_pending=1`;
  - IE=0x00, IF=0x1F: `irq_pending=0`, `start` ignored.
- **Cancel:** slave IF cleared externally between accept and RD_IF → `done` at +2 with `cancelled=1`, no WE pulses, `clr_ime=0`.
- **SP wrap:** `sp=0x0000`, `pc=0xBEEF` → writes 0xFFFF←0xBE, 0xFFFE←0xEF; `new_sp=0xFFFE`.
- **Reset mid-push:** drive `rst=0` during the first WE cycle of PUSH_HI → WE low next edge, stack byte unchanged, no `done`, outputs at reset values; polling resumes after `rst=1`.
